// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the divide sequencer
package mdu_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_seq_if.sv
// rtl/mdu_div_seq_if.sv - EXE-stage request / result bundle for the divide sequencer
interface mdu_div_seq_if;
  logic        EXE_V;
  logic        EXE_Div_Req;
  logic [1:0]  EXE_Div_Op;
  logic        EXE_Div_W;
  logic [63:0] EXE_ALU1;
  logic [63:0] EXE_ALU2;
  logic        EXE_Flush;
  logic        V_EXE_DIV_STALL;
  logic        DIV_Done;
  logic [63:0] DIV_RES;
  logic        DIV_Busy;

  modport master (
    output EXE_V, EXE_Div_Req, EXE_Div_Op, EXE_Div_W, EXE_ALU1, EXE_ALU2, EXE_Flush,
    input  V_EXE_DIV_STALL, DIV_Done, DIV_RES, DIV_Busy
  );

  modport slave (
    input  EXE_V, EXE_Div_Req, EXE_Div_Op, EXE_Div_W, EXE_ALU1, EXE_ALU2, EXE_Flush,
    output V_EXE_DIV_STALL, DIV_Done, DIV_RES, DIV_Busy
  );
endinterface

// File: rtl/mdu_lzc64.sv
// rtl/mdu_lzc64.sv - combinational 64-bit leading-zero counter (64 for an all-zero input)
module mdu_lzc64 (
  input  logic [63:0] a_i,
  output logic [6:0]  cnt_o
);
  always_comb begin
    cnt_o = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (a_i[i]) cnt_o = 7'(63 - i);
    end
  end
endmodule

// File: rtl/mdu_div_seq.sv
// rtl/mdu_div_seq.sv - RV64M iterative restoring divide/remainder sequencer
// Optional early-out pre-normalisation: MDU_DIV_EARLY_OUT_EN
module mdu_div_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic          CLK,
  input  logic          RESET,
  mdu_div_seq_if.slave  div_if
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rem_sel_q, w_q, qneg_q, rneg_q;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q, res_q;

  logic             is_signed, is_rem, s1, s2, div_zero, ovf, zero_div;
  logic [31:0]      a32, b32;
  logic [XLEN-1:0]  a_mag, b_mag, a_ext, spec_res, placed, quo_load;
  logic [CNT_W-1:0] n_load, cnt_load;

  // Operand conditioning for the accept cycle; W dividend sits in the top half so the
  // shared 64-bit shift path yields the 32-bit quotient in quo_q[31:0].
  always_comb begin
    is_signed = ~div_if.EXE_Div_Op[0];
    is_rem    = div_if.EXE_Div_Op[1];
    a32       = div_if.EXE_ALU1[31:0];
    b32       = div_if.EXE_ALU2[31:0];
    if (div_if.EXE_Div_W) begin
      s1       = is_signed & a32[31];
      s2       = is_signed & b32[31];
      a_mag    = {32'd0, s1 ? -a32 : a32};
      b_mag    = {32'd0, s2 ? -b32 : b32};
      a_ext    = sext32(a32);
      div_zero = (b32 == 32'd0);
      ovf      = is_signed && (a32 == INT32_MIN) && (&b32);
      placed   = {a_mag[31:0], 32'd0};
      n_load   = CNT_W'(WLEN);
    end else begin
      s1       = is_signed & div_if.EXE_ALU1[XLEN-1];
      s2       = is_signed & div_if.EXE_ALU2[XLEN-1];
      a_mag    = s1 ? -div_if.EXE_ALU1 : div_if.EXE_ALU1;
      b_mag    = s2 ? -div_if.EXE_ALU2 : div_if.EXE_ALU2;
      a_ext    = div_if.EXE_ALU1;
      div_zero = (div_if.EXE_ALU2 == '0);
      ovf      = is_signed && (div_if.EXE_ALU1 == INT64_MIN) && (&div_if.EXE_ALU2);
      placed   = a_mag;
      n_load   = CNT_W'(XLEN);
    end
    if (div_zero) spec_res = is_rem ? a_ext : '1;
    else          spec_res = is_rem ? '0 : a_ext;
  end

`ifdef MDU_DIV_EARLY_OUT_EN
  logic [6:0] lz;
  mdu_lzc64 u_lzc (.a_i(placed), .cnt_o(lz));
  assign quo_load = placed << lz;
  assign cnt_load = n_load - CNT_W'(lz);
  assign zero_div = (placed == '0);
`else
  assign quo_load = placed;
  assign cnt_load = n_load;
  assign zero_div = 1'b0;
`endif

  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] rem_nx, quo_nx, fix_q, fix_r, fix_sel, fix_res;

  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    rem_nx  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    fix_q   = qneg_q ? -quo_q : quo_q;
    fix_r   = rneg_q ? -rem_q : rem_q;
    fix_sel = rem_sel_q ? fix_r : fix_q;
    fix_res = w_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      w_q       <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
    end else if (div_if.EXE_Flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (div_if.EXE_V && div_if.EXE_Div_Req) begin
          rem_sel_q <= is_rem;
          w_q       <= div_if.EXE_Div_W;
          if (div_zero || ovf) begin
            res_q   <= spec_res;
            state_q <= S_DONE;
          end else begin
            quo_q   <= quo_load;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            qneg_q  <= s1 ^ s2;
            rneg_q  <= s1;
            cnt_q   <= cnt_load;
            state_q <= zero_div ? S_FIXUP : S_CALC;
          end
        end
        S_CALC: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          res_q   <= fix_res;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_if.DIV_Done        = (state_q == S_DONE);
  assign div_if.DIV_RES         = res_q;
  assign div_if.DIV_Busy        = (state_q != S_IDLE);
  assign div_if.V_EXE_DIV_STALL = div_if.EXE_V && div_if.EXE_Div_Req &&
                                  (state_q != S_DONE) && !div_if.EXE_Flush;

endmodule

// File: tb/tb_mdu_div_seq.sv
// tb/tb_mdu_div_seq.sv - randomized bench for mdu_div_seq against an arithmetic reference model
module tb_mdu_div_seq;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_div_seq_if bus();
  mdu_div_seq dut (.CLK(clk), .RESET(rst), .div_if(bus));

  int total = 0;
  int bad   = 0;

  logic        exp_stall = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_busy  = 1'b0;
  logic [63:0] exp_res   = 64'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("stall", 64'(bus.V_EXE_DIV_STALL), 64'(exp_stall));
    chk("done",  64'(bus.DIV_Done),        64'(exp_done));
    chk("busy",  64'(bus.DIV_Busy),        64'(exp_busy));
    chk("res",   bus.DIV_RES,              exp_res);
  end

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      case (op)
        DIV_OP_DIV:  if (b32 == 0) return '1;
                     else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(a32);
                     else return sx($signed(a32) / $signed(b32));
        DIV_OP_REM:  if (b32 == 0) return sx(a32);
                     else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
                     else return sx($signed(a32) % $signed(b32));
        DIV_OP_DIVU: if (b32 == 0) return '1; else return sx(a32 / b32);
        default:     if (b32 == 0) return sx(a32); else return sx(a32 % b32);
      endcase
    end
    case (op)
      DIV_OP_DIV:  if (b == 0) return '1;
                   else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                   else return $signed(a) / $signed(b);
      DIV_OP_REM:  if (b == 0) return a;
                   else if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                   else return $signed(a) % $signed(b);
      DIV_OP_DIVU: if (b == 0) return '1; else return a / b;
      default:     if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Cycles from accept to the DONE cycle.
  function automatic int ref_lat(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [63:0] m;
    int l;
    if (is_special(op, w, a, b)) return 1;
    n = w ? 32 : 64;
    m = w ? {32'd0, a[31:0]} : a;
    if (!op[0] && m[n-1]) m = w ? {32'd0, -a[31:0]} : -a;
    l = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (m[i]) break;
      l++;
    end
`ifdef MDU_DIV_EARLY_OUT_EN
    if (l == n) return 2;
    return n - l + 2;
`else
    if (l > n) return 0;
    return n + 2;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.EXE_V = 1'b0; bus.EXE_Div_Req = 1'b0; bus.EXE_Flush = 1'b0;
      exp_stall = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int flush_at, input int rst_at);
    int lat;
    logic [63:0] r;
    lat = ref_lat(op, w, a, b);
    r   = ref_res(op, w, a, b);
    @(posedge clk); #1;
    bus.EXE_V = 1'b1; bus.EXE_Div_Req = 1'b1; bus.EXE_Flush = 1'b0;
    bus.EXE_Div_Op = op; bus.EXE_Div_W = w; bus.EXE_ALU1 = a; bus.EXE_ALU2 = b;
    exp_stall = 1'b1; exp_done = 1'b0; exp_busy = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      bus.EXE_ALU1 = {$urandom, $urandom};
      bus.EXE_ALU2 = {$urandom, $urandom};
      if (k == flush_at) begin
        bus.EXE_Flush = 1'b1;
        exp_stall = 1'b0; exp_done = 1'b0; exp_busy = 1'b1;
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        bus.EXE_V = 1'b0; bus.EXE_Div_Req = 1'b0;
        #1;
        chk("rst_busy",  64'(bus.DIV_Busy), 64'd0);
        chk("rst_done",  64'(bus.DIV_Done), 64'd0);
        chk("rst_res",   bus.DIV_RES, 64'd0);
        chk("rst_stall", 64'(bus.V_EXE_DIV_STALL), 64'd0);
        exp_stall = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_res = 64'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      exp_busy  = 1'b1;
      exp_done  = (k == lat);
      exp_stall = (k < lat);
      if (k == lat) exp_res = r;
    end
  endtask

  task automatic flush_req();
    @(posedge clk); #1;
    bus.EXE_V = 1'b1; bus.EXE_Div_Req = 1'b1; bus.EXE_Flush = 1'b1;
    bus.EXE_Div_Op = DIV_OP_DIVU; bus.EXE_Div_W = 1'b0;
    bus.EXE_ALU1 = 64'd50; bus.EXE_ALU2 = 64'd5;
    exp_stall = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic        w;
    logic [63:0] a, b;
    bus.EXE_V = 1'b0; bus.EXE_Div_Req = 1'b0; bus.EXE_Div_Op = 2'b00; bus.EXE_Div_W = 1'b0;
    bus.EXE_ALU1 = 64'd0; bus.EXE_ALU2 = 64'd0; bus.EXE_Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_div",   ref_res(DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("model_rem",   ref_res(DIV_OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("model_divuw", ref_res(DIV_OP_DIVU, 1'b1, '1, 64'd2), 64'h0000_0000_7FFF_FFFF);
    chk("model_lat_w", 64'(ref_lat(DIV_OP_DIVU, 1'b1, '1, 64'd2)), 64'd34);
`ifndef MDU_DIV_EARLY_OUT_EN
    chk("model_lat64", 64'(ref_lat(DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3)), 64'd66);
`endif

    run_op(DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, -1, -1);
    chk("tp1_res", bus.DIV_RES, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("tp1_done", 64'(bus.DIV_Done), 64'd1);
    run_op(DIV_OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, -1, -1);
    chk("tp2_rem", bus.DIV_RES, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(1);
    run_op(DIV_OP_REMU, 1'b0, 64'd20, 64'd3, -1, -1);
    chk("tp2_remu", bus.DIV_RES, 64'd2);
    run_op(DIV_OP_DIVU, 1'b0, 64'd77, 64'd0, -1, -1);
    chk("tp3_divu0", bus.DIV_RES, '1);
    run_op(DIV_OP_REMU, 1'b0, 64'h1234, 64'd0, -1, -1);
    chk("tp3_remu0", bus.DIV_RES, 64'h1234);
    run_op(DIV_OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, -1, -1);
    chk("tp4_divw", bus.DIV_RES, 64'hFFFF_FFFF_8000_0000);
    run_op(DIV_OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, -1, -1);
    chk("tp4_remw", bus.DIV_RES, 64'd0);
    run_op(DIV_OP_DIVU, 1'b1, '1, 64'd2, -1, -1);
    chk("tp5_divuw", bus.DIV_RES, 64'h0000_0000_7FFF_FFFF);
    idle(2);
    run_op(DIV_OP_DIVU, 1'b0, 64'hFFFF_0000_1234_5678, 64'd9, 10, -1);
    run_op(DIV_OP_DIVU, 1'b0, 64'd100, 64'd7, -1, -1);
    chk("tp6_after_flush", bus.DIV_RES, 64'd14);
    run_op(DIV_OP_DIV, 1'b0, 64'hFFFF_FFFF_0000_0001, 64'd3, -1, 20);
    flush_req();
    idle(2);

    for (int t = 0; t < 60; t++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin
          op[0] = 1'b0;
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2: a = 64'd0;
        3: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        4: b = 64'($urandom_range(1, 300)) * (($urandom_range(0, 1) == 1) ? 64'd1 : '1);
        default: ;
      endcase
      run_op(op, w, a, b, -1, -1);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
